apb_master: RTL and testbench

//  AMBA APB (APB4-style) bus master bridging a simple local request interface to two APB slaves.
//  - Local side: transfer request flag, direction, read/write addresses, write data, byte strobes, slave select.
//  - Bus side: drives the APB SETUP/ACCESS protocol and honours PREADY wait states.
//  - Returns read data and slave error to the requester; sits between the system controller and the GPIO/UART slaves.

---
 rtl/apb_master.sv | 174 +++++++++++++++++
 tb/tb_apb_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB4-style master: bridges a local request interface to two APB slaves.
// SETUP values pass through from the inputs, are latched on entry to ACCESS and held until PREADY.
module apb_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int STRB_WIDTH    = 4,
   parameter int SLAVE_NUM     = 2
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic                     TRANSFER_FLAG,
   input  logic                     READ1_WRITE0,
   input  logic [ADDRESS_WIDTH-1:0] APB_writeAddress,
   input  logic [ADDRESS_WIDTH-1:0] APB_readAddress,
   input  logic [DATA_WIDTH-1:0]    APB_writeData,
   input  logic [STRB_WIDTH-1:0]    IN_STRB,
   input  logic [SLAVE_NUM-1:0]     Slave_Select,
   input  logic [DATA_WIDTH-1:0]    PRDATA,
   input  logic                     PREADY,
   input  logic                     PSLVERR,
   output logic [ADDRESS_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0]    PWDATA,
   output logic [STRB_WIDTH-1:0]    PSTRB,
   output logic                     PWRITE,
   output logic                     PSEL1,
   output logic                     PSEL2,
   output logic                     PENABLE,
   output logic [DATA_WIDTH-1:0]    APB_readData,
   output logic                     OUT_SLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [ADDRESS_WIDTH-1:0]   r_paddr;
   logic [DATA_WIDTH-1:0]      r_pwdata;
   logic [STRB_WIDTH-1:0]      r_pstrb;
   logic                       r_pwrite;
   logic                       r_psel1;
   logic                       r_psel2;
   logic [DATA_WIDTH-1:0]      r_rdata;
   logic                       r_slverr;

   logic                       w_sel1;
   logic                       w_sel2;
   logic                       w_write;
   logic [ADDRESS_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]      w_wdata;
   logic [STRB_WIDTH-1:0]      w_strb;
   logic                       w_done;

   assign w_sel1  = (Slave_Select == SLAVE_NUM'(1));
   assign w_sel2  = (Slave_Select == SLAVE_NUM'(2));
   assign w_write = ~READ1_WRITE0;
   assign w_addr  = w_write ? APB_writeAddress : APB_readAddress;
   assign w_wdata = w_write ? APB_writeData : {DATA_WIDTH{1'b0}};
   assign w_strb  = w_write ? IN_STRB : {STRB_WIDTH{1'b0}};
   assign w_done  = (r_state == ST_ACCESS) && PREADY;

   assign APB_readData = r_rdata;
   assign OUT_SLVERR   = r_slverr;

   // State register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (TRANSFER_FLAG && (w_sel1 || w_sel2)) begin
               w_next = ST_SETUP;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!PREADY) begin
               w_next = ST_ACCESS;
            end else if (TRANSFER_FLAG) begin
               w_next = ST_SETUP;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Latch the SETUP-phase bus values so ACCESS ignores input changes
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_paddr  <= {ADDRESS_WIDTH{1'b0}};
         r_pwdata <= {DATA_WIDTH{1'b0}};
         r_pstrb  <= {STRB_WIDTH{1'b0}};
         r_pwrite <= 1'b0;
         r_psel1  <= 1'b0;
         r_psel2  <= 1'b0;
      end else if (r_state == ST_SETUP) begin
         r_paddr  <= w_addr;
         r_pwdata <= w_wdata;
         r_pstrb  <= w_strb;
         r_pwrite <= w_write;
         r_psel1  <= w_sel1;
         r_psel2  <= w_sel2;
      end
   end

   // Completion results, held until the next completed transfer
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rdata  <= {DATA_WIDTH{1'b0}};
         r_slverr <= 1'b0;
      end else if (w_done) begin
         r_slverr <= PSLVERR;
         if (!r_pwrite) begin
            r_rdata <= PRDATA;
         end
      end
   end

   // Bus outputs: pass-through in SETUP, latched in ACCESS, quiet in IDLE
   always_comb begin
      PADDR   = {ADDRESS_WIDTH{1'b0}};
      PWDATA  = {DATA_WIDTH{1'b0}};
      PSTRB   = {STRB_WIDTH{1'b0}};
      PWRITE  = 1'b0;
      PSEL1   = 1'b0;
      PSEL2   = 1'b0;
      PENABLE = 1'b0;
      case (r_state)
         ST_IDLE: begin
            PENABLE = 1'b0;
         end
         ST_SETUP: begin
            PADDR  = w_addr;
            PWDATA = w_wdata;
            PSTRB  = w_strb;
            PWRITE = w_write;
            PSEL1  = w_sel1;
            PSEL2  = w_sel2;
         end
         ST_ACCESS: begin
            PADDR   = r_paddr;
            PWDATA  = r_pwdata;
            PSTRB   = r_pstrb;
            PWRITE  = r_pwrite;
            PSEL1   = r_psel1;
            PSEL2   = r_psel2;
            PENABLE = 1'b1;
         end
         default: begin
            PENABLE = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: writes, reads, wait states, slave error, async reset.
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        TRANSFER_FLAG;
   logic        READ1_WRITE0;
   logic [31:0] APB_writeAddress;
   logic [31:0] APB_readAddress;
   logic [31:0] APB_writeData;
   logic [3:0]  IN_STRB;
   logic [1:0]  Slave_Select;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PWRITE;
   logic        PSEL1;
   logic        PSEL2;
   logic        PENABLE;
   logic [31:0] APB_readData;
   logic        OUT_SLVERR;

   int n_total = 0;
   int n_bad   = 0;

   apb_master dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .TRANSFER_FLAG(TRANSFER_FLAG),
      .READ1_WRITE0(READ1_WRITE0), .APB_writeAddress(APB_writeAddress),
      .APB_readAddress(APB_readAddress), .APB_writeData(APB_writeData),
      .IN_STRB(IN_STRB), .Slave_Select(Slave_Select), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDR(PADDR), .PWDATA(PWDATA),
      .PSTRB(PSTRB), .PWRITE(PWRITE), .PSEL1(PSEL1), .PSEL2(PSEL2),
      .PENABLE(PENABLE), .APB_readData(APB_readData), .OUT_SLVERR(OUT_SLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic req(input logic t, input logic rd, input logic [1:0] sel,
                      input logic [31:0] wa, input logic [31:0] ra,
                      input logic [31:0] wd, input logic [3:0] st);
      TRANSFER_FLAG    = t;
      READ1_WRITE0     = rd;
      Slave_Select     = sel;
      APB_writeAddress = wa;
      APB_readAddress  = ra;
      APB_writeData    = wd;
      IN_STRB          = st;
   endtask

   initial begin
      PRESETn = 1'b0;
      req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
      PRDATA  = 32'h0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      #2;
      check("rst_penable", {31'h0, PENABLE}, 32'h0);
      check("rst_psel",    {30'h0, PSEL2, PSEL1}, 32'h0);
      check("rst_rdata",   APB_readData, 32'h0);
      check("rst_slverr",  {31'h0, OUT_SLVERR}, 32'h0);
      #10 PRESETn = 1'b1;
      tick();

      // write, no wait, then back-to-back write to slave 2
      req(1'b1, 1'b0, 2'b01, 32'h4CD3, 32'h1111, 32'd98, 4'hF);
      PREADY = 1'b1;
      tick();
      check("w1_setup_psel1",  {31'h0, PSEL1}, 32'h1);
      check("w1_setup_penab",  {31'h0, PENABLE}, 32'h0);
      check("w1_setup_paddr",  PADDR, 32'h4CD3);
      check("w1_setup_pwdata", PWDATA, 32'd98);
      check("w1_setup_pwrite", {31'h0, PWRITE}, 32'h1);
      check("w1_setup_pstrb",  {28'h0, PSTRB}, 32'hF);
      tick();
      check("w1_acc_penab", {31'h0, PENABLE}, 32'h1);
      req(1'b1, 1'b0, 2'b10, 32'hB6B9, 32'h2222, 32'd105, 4'h5);
      #1;
      check("w1_acc_paddr_held", PADDR, 32'h4CD3);
      check("w1_acc_pwdata_held", PWDATA, 32'd98);
      check("w1_acc_psel_held", {30'h0, PSEL2, PSEL1}, 32'h1);
      tick();
      check("w2_setup_penab",  {31'h0, PENABLE}, 32'h0);
      check("w2_setup_psel",   {30'h0, PSEL2, PSEL1}, 32'h2);
      check("w2_setup_paddr",  PADDR, 32'hB6B9);
      check("w2_setup_pwdata", PWDATA, 32'd105);
      TRANSFER_FLAG = 1'b0;
      tick();
      check("w2_acc_penab", {31'h0, PENABLE}, 32'h1);
      check("w2_acc_pstrb", {28'h0, PSTRB}, 32'h5);
      tick();
      check("w2_idle_penab", {31'h0, PENABLE}, 32'h0);
      check("w2_idle_psel",  {30'h0, PSEL2, PSEL1}, 32'h0);
      tick();
      check("w2_idle2_penab", {31'h0, PENABLE}, 32'h0);

      // write with two wait states
      req(1'b1, 1'b0, 2'b01, 32'h1234, 32'h0, 32'hAA, 4'h3);
      PREADY = 1'b0;
      tick();
      check("ww_setup_paddr", PADDR, 32'h1234);
      TRANSFER_FLAG = 1'b0;
      tick();
      APB_writeAddress = 32'hDEAD;
      APB_writeData    = 32'hBEEF;
      for (int i = 0; i < 2; i++) begin
         check("ww_wait_penab",  {31'h0, PENABLE}, 32'h1);
         check("ww_wait_paddr",  PADDR, 32'h1234);
         check("ww_wait_pwdata", PWDATA, 32'hAA);
         tick();
      end
      check("ww_last_penab", {31'h0, PENABLE}, 32'h1);
      PREADY = 1'b1;
      tick();
      check("ww_done_penab",  {31'h0, PENABLE}, 32'h0);
      check("ww_done_slverr", {31'h0, OUT_SLVERR}, 32'h0);

      // read, no wait, then back-to-back read from slave 2
      req(1'b1, 1'b1, 2'b01, 32'h7777, 32'hBAB8, 32'h5A5A, 4'hF);
      tick();
      check("r1_setup_paddr",  PADDR, 32'hBAB8);
      check("r1_setup_pwrite", {31'h0, PWRITE}, 32'h0);
      check("r1_setup_pwdata", PWDATA, 32'h0);
      check("r1_setup_pstrb",  {28'h0, PSTRB}, 32'h0);
      PRDATA = 32'd98;
      tick();
      req(1'b1, 1'b1, 2'b10, 32'h7777, 32'h4CD3, 32'h5A5A, 4'hF);
      #1;
      check("r1_acc_paddr_held", PADDR, 32'hBAB8);
      tick();
      check("r1_rdata",        APB_readData, 32'd98);
      check("r2_setup_penab",  {31'h0, PENABLE}, 32'h0);
      check("r2_setup_psel",   {30'h0, PSEL2, PSEL1}, 32'h2);
      check("r2_setup_paddr",  PADDR, 32'h4CD3);
      PRDATA = 32'd150;
      TRANSFER_FLAG = 1'b0;
      tick();
      tick();
      check("r2_rdata",      APB_readData, 32'd150);
      check("r2_idle_psel",  {30'h0, PSEL2, PSEL1}, 32'h0);
      check("r2_idle_penab", {31'h0, PENABLE}, 32'h0);

      // read with two wait states and slave error
      req(1'b1, 1'b1, 2'b01, 32'h0, 32'h0040, 32'h0, 4'hF);
      PREADY = 1'b0;
      PRDATA = 32'h55;
      tick();
      TRANSFER_FLAG = 1'b0;
      tick();
      check("re_wait_pstrb", {28'h0, PSTRB}, 32'h0);
      tick();
      check("re_wait_rdata_held", APB_readData, 32'd150);
      PREADY  = 1'b1;
      PRDATA  = 32'd90;
      PSLVERR = 1'b1;
      tick();
      check("re_rdata",  APB_readData, 32'd90);
      check("re_slverr", {31'h0, OUT_SLVERR}, 32'h1);
      PSLVERR = 1'b0;

      // write leaves read data alone and clears the error flag
      req(1'b1, 1'b0, 2'b10, 32'h0100, 32'h0, 32'h33, 4'hF);
      PRDATA = 32'h99;
      tick();
      TRANSFER_FLAG = 1'b0;
      tick();
      tick();
      check("wr_keeps_rdata", APB_readData, 32'd90);
      check("wr_clr_slverr",  {31'h0, OUT_SLVERR}, 32'h0);

      // async reset in the middle of ACCESS
      req(1'b1, 1'b0, 2'b01, 32'h0F0F, 32'h0, 32'h77, 4'hF);
      PREADY = 1'b0;
      tick();
      tick();
      check("rs_pre_penab", {31'h0, PENABLE}, 32'h1);
      #2 PRESETn = 1'b0;
      #1;
      check("rs_penab",  {31'h0, PENABLE}, 32'h0);
      check("rs_psel",   {30'h0, PSEL2, PSEL1}, 32'h0);
      check("rs_paddr",  PADDR, 32'h0);
      check("rs_pwdata", PWDATA, 32'h0);
      check("rs_rdata",  APB_readData, 32'h0);
      TRANSFER_FLAG = 1'b0;
      #3 PRESETn = 1'b1;
      tick();
      tick();
      check("rs_idle_psel", {30'h0, PSEL2, PSEL1}, 32'h0);

      // invalid selects never start a transfer
      req(1'b1, 1'b0, 2'b11, 32'h0AAA, 32'h0, 32'h1, 4'hF);
      tick();
      tick();
      check("sel11_psel",  {30'h0, PSEL2, PSEL1}, 32'h0);
      check("sel11_penab", {31'h0, PENABLE}, 32'h0);
      Slave_Select = 2'b00;
      tick();
      tick();
      check("sel00_penab", {31'h0, PENABLE}, 32'h0);
      check("sel00_paddr", PADDR, 32'h0);
      Slave_Select = 2'b01;
      tick();
      check("restart_psel1", {31'h0, PSEL1}, 32'h1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
